// File: rtl/switch_input_port.sv
// switch_input_port: memory-mapped switch input peripheral.
// Synchronises and debounces N_SW raw switch pins, latches per-switch
// change flags (write-1-to-clear), drives a registered interrupt and keeps
// a CPU-writable snapshot register that can track the debounced switches.
// Optional feature macro: SWPORT_EDGE_SEL_EN adds CTRL bit2 RISE_ONLY,
// which restricts flag setting to 0->1 transitions of the debounced level.
//
// Register map (unused upper bits read 0):
//   addr 0 STATE (RO)  : debounced switch levels
//   addr 1 FLAGS (W1C) : latched change flags
//   addr 2 CTRL  (RW)  : bit0 LIVE, bit1 IRQ_EN, bit2 RISE_ONLY (optional)
//   addr 3 SNAP  (RW)  : full-width snapshot
module switch_input_port #(
    parameter int ANCHO      = 32,
    parameter int N_SW       = 16,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             WE,
    input  logic [1:0]       addr,
    input  logic [ANCHO-1:0] Entrada,
    output logic [ANCHO-1:0] Salida,
    input  logic [N_SW-1:0]  sw,
    output logic             irq
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

`ifdef SWPORT_EDGE_SEL_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_FLAGS = 2'd1;
    localparam logic [1:0] A_CTRL  = 2'd2;
    localparam logic [1:0] A_SNAP  = 2'd3;

    logic [N_SW-1:0]   r_sync_p0;
    logic [N_SW-1:0]   r_sync_p1;
    logic [CNT_W-1:0]  r_cnt [N_SW];
    logic [N_SW-1:0]   r_stable;
    logic [N_SW-1:0]   r_flags;
    logic [CTRL_W-1:0] r_ctrl;
    logic [ANCHO-1:0]  r_snap;
    logic              r_irq;

    logic [CNT_W-1:0]  w_cnt_nxt [N_SW];
    logic [N_SW-1:0]   w_stable_nxt;
    logic [N_SW-1:0]   w_flag_set;
    logic [ANCHO-1:0]  w_stable_ext;
    logic              w_wr;
    logic              w_live;
    logic              w_irq_en;

    assign w_wr     = WE & sel;
    assign w_live   = r_ctrl[0];
    assign w_irq_en = r_ctrl[1];
    assign irq      = r_irq;

    // Two-flop synchroniser per switch pin
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= sw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Debounce: count consecutive mismatches, accept the new level on the last one
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < N_SW; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync_p1[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_nxt[i] = r_sync_p1[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters and accepted switch levels
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int i = 0; i < N_SW; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Which debounced transitions raise a flag (any change, or rises only)
    always_comb begin
`ifdef SWPORT_EDGE_SEL_EN
        if (r_ctrl[2]) begin
            w_flag_set = w_stable_nxt & ~r_stable;
        end else begin
            w_flag_set = w_stable_nxt ^ r_stable;
        end
`else
        w_flag_set = w_stable_nxt ^ r_stable;
`endif
    end

    // Change flags: W1C clear first, a simultaneous new event re-sets the bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_wr && addr == A_FLAGS) begin
            r_flags <= (r_flags & ~Entrada[N_SW-1:0]) | w_flag_set;
        end else begin
            r_flags <= r_flags | w_flag_set;
        end
    end

    // Control register; only implemented bits are stored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (w_wr && addr == A_CTRL) begin
            r_ctrl <= Entrada[CTRL_W-1:0];
        end
    end

    // Zero-extended debounced levels for the snapshot and STATE read
    always_comb begin
        w_stable_ext             = '0;
        w_stable_ext[N_SW-1:0]   = r_stable;
    end

    // Snapshot: CPU write beats live tracking, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_wr && addr == A_SNAP) begin
            r_snap <= Entrada;
        end else if (w_live) begin
            r_snap <= w_stable_ext;
        end
    end

    // Interrupt request, one cycle behind the flags and enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_en & (|r_flags);
        end
    end

    // Read mux, combinational from addr and current register contents
    always_comb begin
        Salida = '0;
        case (addr)
            A_STATE: Salida = w_stable_ext;
            A_FLAGS: Salida[N_SW-1:0]   = r_flags;
            A_CTRL:  Salida[CTRL_W-1:0] = r_ctrl;
            A_SNAP:  Salida = r_snap;
            default: Salida = '0;
        endcase
    end

endmodule

// File: doc/switch_input_port.md
Name: switch_input_port

Overview:
- Memory-mapped switch input peripheral for the microprocessor bus. Generalises the single switch-snapshot register.
- Synchronises and debounces N_SW switch inputs, and latches per-switch change flags with an optional interrupt.
- Keeps a CPU-writable snapshot register that can track the live debounced switches.
- Sits on the data bus behind the external address decoder, next to the other I/O blocks.

Parameters:
- ANCHO, 32, data bus width; must be >= N_SW.
- N_SW, 16, number of switch inputs; 1..ANCHO.
- DEB_CYCLES, 4, consecutive stable cycles required to accept a new switch level; >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sel  in  1  block selected by the external address decoder.
- WE  in  1  write strobe; effective write = WE & sel.
- addr  in  2  register index.
- Entrada  in  ANCHO  write data.
- Salida  out  ANCHO  read data; combinational from addr and current register contents.
- sw  in  N_SW  raw asynchronous switch pins.
- irq  out  1  registered interrupt request.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On rst: sync flops, debounce counters, stable, flags, ctrl, snap and irq all go to 0. A reset mid-debounce discards any count in progress.
- Register map, with unused upper bits reading 0:
  - addr 0 STATE (RO): {0, stable}.
  - addr 1 FLAGS (W1C): {0, flags}.
  - addr 2 CTRL (RW): bit0 LIVE, bit1 IRQ_EN, other bits read 0.
  - addr 3 SNAP (RW): full ANCHO bits.
- Synchroniser: two flops per switch, so sync = sw delayed 2 cycles.
- Debounce, per bit i:
  - If sync[i] == stable[i], then cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEB_CYCLES-1, then stable[i] <= sync[i] and cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i] + 1.
  - A mismatch must hold for DEB_CYCLES consecutive edges. A glitch shorter than that resets the count and never reaches stable.
  - Pin-to-stable latency is 2 + DEB_CYCLES cycles.
  - Counter width is clog2(DEB_CYCLES), minimum 1.
- Flags:
  - flags[i] sets on the edge where stable[i] changes.
  - A write to addr 1 clears each bit where Entrada[i] = 1.
  - If set and clear hit the same cycle, set wins and the flag stays 1.
- Snapshot, priority order:
  1. Effective write to addr 3 loads Entrada.
  2. Else if LIVE = 1, snap <= zero-extended stable every cycle.
  3. Else snap holds.
- irq <= IRQ_EN & (|flags), registered with one cycle of lag.
  - Clearing IRQ_EN drops irq on the next edge; flags are retained.
- Writes to addr 0 are ignored. Reads have no side effects.
- Writes with sel = 0 are ignored regardless of WE.

Optional Feature:
- Macro: SWPORT_EDGE_SEL_EN.
- Defined: CTRL bit2 is RISE_ONLY (RW, reset 0). When RISE_ONLY = 1, flags set only on stable 0->1 transitions; when 0, they set on any change.
- Not defined: CTRL bit2 reads 0 and ignores writes; flags set on any change.

Test Plan (DEB_CYCLES=4, N_SW=16, ANCHO=32):
- Reset then idle: all registers read 0 and irq=0. Set sw[3]=1 and hold → STATE reads 0x0000_0008 exactly 6 cycles after the pin change; FLAGS=0x8.
- Glitch: sw[5] high for 3 cycles then low → STATE and FLAGS stay 0. Then hold sw[5] high for 4 cycles → STATE bit5 = 1.
- Interrupt: CTRL=0x2, toggle sw[0] → irq=1 one cycle after the flag sets. Write FLAGS=0x1 → flags=0 and irq=0 next cycle. Make a new change coincide with the W1C write → flag stays 1.
- Snapshot: CTRL=0x1 with sw=0xA5A5 → SNAP=0x0000_A5A5. Write SNAP=0xDEAD_BEEF while LIVE → reads 0xDEAD_BEEF for that cycle, then tracks stable again. CTRL=0 → SNAP holds.
- sel=0 with WE=1 on every addr → no register changes. Assert rst mid-debounce → stable stays 0 and the count restarts from 0.
- SWPORT_EDGE_SEL_EN defined: CTRL=0x4, sw[2] 0->1->0 → FLAGS bit2 sets only on the rise. Not defined: CTRL write 0x4 reads back 0.
